// File: rtl/st_pkg.sv
// Shared types and helpers for the Avalon-ST width downsizer: holding-record
// geometry, slice index width, FSM state encoding and last-slice computation.
package st_pkg;

    localparam int ST_IN_BYTES  = 4;
    localparam int ST_OUT_BYTES = 1;
    localparam int ST_RATIO     = ST_IN_BYTES / ST_OUT_BYTES;

    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int ST_IDX_W   = idx_width(ST_RATIO);
    localparam int ST_EMPTY_W = (ST_IN_BYTES > 1) ? $clog2(ST_IN_BYTES) : 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ST_IN_BYTES*8-1:0] data;
        logic                     sop;
        logic                     eop;
        logic [ST_EMPTY_W-1:0]    empty;
        logic [ST_IDX_W-1:0]      last_idx;
    } hold_t;

    // Index of the final narrow slice to emit; an out-of-range empty clamps to slice 0.
    function automatic logic [ST_IDX_W-1:0] slice_last_idx(input logic [ST_EMPTY_W-1:0] empty,
                                                            input logic                  eop);
        int e;
        e = int'(empty);
        if (!eop)
            return ST_IDX_W'(ST_RATIO - 1);
        if (e >= ST_IN_BYTES)
            return '0;
        return ST_IDX_W'(ST_RATIO - 1 - (e / ST_OUT_BYTES));
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data, vld/rdy handshake and sop/eop/empty framing.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 4
);
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             vld;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;

    modport source (output data, vld, sop, eop, empty, input rdy);
    modport sink   (input data, vld, sop, eop, empty, output rdy);

endinterface

// File: rtl/st_width_downsizer.sv
// Wide-to-narrow Avalon-ST converter with a one-beat holding register, MSB slice first.
// Optional framing checker enabled by defining ST_DOWNSIZER_PROTO_CHECK_EN (adds proto_err).
module st_width_downsizer
    import st_pkg::*;
#(
    parameter int IN_BYTES  = ST_IN_BYTES,
    parameter int OUT_BYTES = ST_OUT_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    avalon_st_if.sink   in,
    avalon_st_if.source out,
    output logic        busy
`ifdef ST_DOWNSIZER_PROTO_CHECK_EN
    ,
    output logic        proto_err
`endif
);

    localparam int RATIO       = IN_BYTES / OUT_BYTES;
    localparam int IN_BITS     = IN_BYTES * 8;
    localparam int OUT_BITS    = OUT_BYTES * 8;
    localparam int OUT_EMPTY_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    if (RATIO < 2 || (IN_BYTES % OUT_BYTES) != 0) begin : g_bad_ratio
        $error("st_width_downsizer: IN_BYTES must be a multiple of OUT_BYTES with ratio >= 2");
    end
    if (IN_BYTES != ST_IN_BYTES || OUT_BYTES != ST_OUT_BYTES) begin : g_bad_geometry
        $error("st_width_downsizer: parameters must match the st_pkg holding-record geometry");
    end

    state_t                   state_reg;
    hold_t                    hold_reg;
    hold_t                    hold_next;
    logic [ST_IDX_W-1:0]      idx_reg;
    logic                     hold_vld;
    logic                     out_xfer;
    logic                     last_xfer;
    logic                     accept;
    logic                     eop_now;
    logic [OUT_EMPTY_W-1:0]   empty_mod;
    logic [OUT_BITS-1:0]      slices [RATIO];

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign slices[gi] = hold_reg.data[IN_BITS-1-gi*OUT_BITS -: OUT_BITS];
    end

    assign hold_vld  = (state_reg == S_HOLD);
    assign out_xfer  = hold_vld && out.rdy;
    assign last_xfer = out_xfer && (idx_reg == hold_reg.last_idx);
    // Refill in the same cycle the final slice leaves, so back-to-back beats have no bubble.
    assign in.rdy    = !hold_vld || last_xfer;
    assign accept    = in.vld && in.rdy;

    always_comb begin
        hold_next          = '0;
        hold_next.data     = in.data;
        hold_next.sop      = in.sop;
        hold_next.eop      = in.eop;
        hold_next.empty    = in.empty;
        hold_next.last_idx = slice_last_idx(in.empty, in.eop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_EMPTY;
            hold_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                S_EMPTY: begin
                    if (accept) begin
                        state_reg <= S_HOLD;
                        hold_reg  <= hold_next;
                        idx_reg   <= '0;
                    end
                end
                S_HOLD: begin
                    if (last_xfer) begin
                        idx_reg <= '0;
                        if (accept)
                            hold_reg <= hold_next;
                        else
                            state_reg <= S_EMPTY;
                    end else if (out_xfer) begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= S_EMPTY;
            endcase
        end
    end

    assign eop_now   = hold_vld && hold_reg.eop && (idx_reg == hold_reg.last_idx);
    assign empty_mod = OUT_EMPTY_W'(32'(hold_reg.empty) % OUT_BYTES);

    assign out.vld   = hold_vld;
    assign out.data  = slices[idx_reg];
    assign out.sop   = hold_vld && hold_reg.sop && (idx_reg == '0);
    assign out.eop   = eop_now;
    assign out.empty = eop_now ? empty_mod : '0;
    assign busy      = hold_vld;

`ifdef ST_DOWNSIZER_PROTO_CHECK_EN
    logic in_pkt_reg;
    logic proto_err_reg;

    // Sticky: a sop inside a packet, or a non-sop beat outside one, is a framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_reg    <= 1'b0;
            proto_err_reg <= 1'b0;
        end else if (accept) begin
            if (in.sop == in_pkt_reg)
                proto_err_reg <= 1'b1;
            in_pkt_reg <= !in.eop;
        end
    end

    assign proto_err = proto_err_reg;
`endif

endmodule

// File: tb/tb_st_width_downsizer.sv
// Scoreboard bench for st_width_downsizer (IN_BYTES=4, OUT_BYTES=1): accepted wide
// beats are expanded into expected narrow beats and compared as the DUT emits them.
module tb_st_width_downsizer;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       empty;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef ST_DOWNSIZER_PROTO_CHECK_EN
    logic proto_err;
`endif

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) in_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) out_if ();

    st_width_downsizer #(.IN_BYTES(4), .OUT_BYTES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_if),
        .out       (out_if),
        .busy      (busy)
`ifdef ST_DOWNSIZER_PROTO_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic        stall_prev = 1'b0;
    logic [10:0] stall_val  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
        int   last;
        exp_t x;
        last = 3;
        if (e)
            last = (int'(em) >= 4) ? 0 : 3 - int'(em);
        for (int k = 0; k <= last; k++) begin
            x.data  = d[31-8*k -: 8];
            x.sop   = s && (k == 0);
            x.eop   = e && (k == last);
            x.empty = 1'b0;
            sb_q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_if.vld)
                chk("stall_stable", {out_if.data, out_if.sop, out_if.eop, out_if.empty}, stall_val);
            if (out_if.vld && out_if.rdy) begin
                $display("out beat %0d: data=%02h sop=%0b eop=%0b empty=%0b",
                         n_out, out_if.data, out_if.sop, out_if.eop, out_if.empty);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("out_data",  out_if.data,  e.data);
                    chk("out_sop",   out_if.sop,   e.sop);
                    chk("out_eop",   out_if.eop,   e.eop);
                    chk("out_empty", out_if.empty, e.empty);
                end
                n_out++;
            end
            if (in_if.vld && in_if.rdy)
                push_beat(in_if.data, in_if.sop, in_if.eop, in_if.empty);
            stall_prev = out_if.vld && !out_if.rdy;
            stall_val  = {out_if.data, out_if.sop, out_if.eop, out_if.empty};
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
        int n;
        n = 0;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = em;
        in_if.vld   = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (in_if.rdy !== 1'b1 && n < 100);
        chk("accept_rdy", in_if.rdy, 1);
        @(posedge clk);
        #1;
        in_if.vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int target);
        int n;
        n = 0;
        while (n_out < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("wait_out", n_out >= target, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        logic [3:0] pat;

        in_if.vld   = 1'b0;
        in_if.data  = '0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.empty = '0;
        out_if.rdy  = 1'b1;
        pat         = 4'b1001;

        // Reset state
        #12;
        chk("rst_vld",   out_if.vld,   0);
        chk("rst_sop",   out_if.sop,   0);
        chk("rst_eop",   out_if.eop,   0);
        chk("rst_empty", out_if.empty, 0);
        chk("rst_data",  out_if.data,  0);
        chk("rst_busy",  busy,         0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_rdy", in_if.rdy, 1);
        @(posedge clk);
        #1;

        // Single beat, first slice one cycle after accept, in.rdy low for 3 cycles
        send_beat(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0);
        chk("lat_vld",  out_if.vld,  1);
        chk("lat_data", out_if.data, 8'hA1);
        chk("lat_sop",  out_if.sop,  1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_in_rdy", in_if.rdy, (i == 3) ? 1 : 0);
        end
        wait_idle();

        // Short eop: second beat with empty=2 emits only two slices
        n0 = n_out;
        send_beat(32'h55667788, 1'b1, 1'b0, 2'd0);
        send_beat(32'h11223344, 1'b0, 1'b1, 2'd2);
        wait_idle();
        chk("short_count", n_out - n0, 6);

        // empty=3 leaves last_idx=0: sop and eop on one slice
        n0 = n_out;
        send_beat(32'h99AABBCC, 1'b1, 1'b1, 2'd3);
        wait_idle();
        chk("one_slice_count", n_out - n0, 1);

        // Back-pressure pattern 1,0,0,1
        n0 = n_out;
        fork
            send_beat(32'hCAFEF00D, 1'b1, 1'b1, 2'd0);
            begin
                for (int i = 0; i < 16; i++) begin
                    out_if.rdy = pat[3 - (i % 4)];
                    @(posedge clk);
                    #1;
                end
                out_if.rdy = 1'b1;
            end
        join
        wait_idle();
        chk("bp_count", n_out - n0, 4);

        // Back-to-back: 12 narrow beats with no bubble, in.rdy every 4th cycle
        n0 = n_out;
        fork
            begin
                send_beat(32'h01020304, 1'b1, 1'b0, 2'd0);
                send_beat(32'h05060708, 1'b0, 1'b0, 2'd0);
                send_beat(32'h090A0B0C, 1'b0, 1'b1, 2'd0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (out_if.vld !== 1'b1 && n < 20);
                chk("b2b_start", out_if.vld, 1);
                for (int i = 0; i < 12; i++) begin
                    chk("b2b_vld",    out_if.vld, 1);
                    chk("b2b_in_rdy", in_if.rdy,  (i % 4 == 3) ? 1 : 0);
                    @(negedge clk);
                end
            end
        join
        wait_idle();
        chk("b2b_count", n_out - n0, 12);

        // Reset mid-beat, after slice B2 has been taken
        n0 = n_out;
        send_beat(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0);
        wait_out(n0 + 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld",  out_if.vld, 0);
        chk("midrst_busy", busy,       0);
        chk("midrst_eop",  out_if.eop, 0);
        sb_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        chk("postrst_in_rdy", in_if.rdy,  1);
        chk("postrst_vld",    out_if.vld, 0);
        @(posedge clk);
        #1;
        send_beat(32'hDEADBEEF, 1'b1, 1'b1, 2'd0);
        chk("postrst_sop",  out_if.sop,  1);
        chk("postrst_data", out_if.data, 8'hDE);
        wait_idle();

`ifdef ST_DOWNSIZER_PROTO_CHECK_EN
        // Two sop beats without an eop between them
        chk("proto_clean", proto_err, 0);
        send_beat(32'h10203040, 1'b1, 1'b0, 2'd0);
        chk("proto_first_sop", proto_err, 0);
        send_beat(32'h50607080, 1'b1, 1'b0, 2'd0);
        chk("proto_set", proto_err, 1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("proto_sticky", proto_err, 1);
        rst_n = 1'b0;
        #1;
        chk("proto_rst", proto_err, 0);
        sb_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
